// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: picks the next fetch PC from the D-stage decision and flags bad fetch addresses.
// Optional branch-likely support (npc_op=4, F_nullify) is enabled by defining PC_SEQUENCER_BLIKELY_EN.
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  npc_op,
  input  logic        cmp_out,
  input  logic [31:0] D_PC,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_index,
  input  logic [31:0] D_rs,
  output logic [31:0] F_PC,
  output logic [31:0] link_pc,
  output logic        F_adel,
  output logic        F_nullify
);

  localparam logic [2:0]  OP_SEQ    = 3'd0;
  localparam logic [2:0]  OP_BRANCH = 3'd1;
  localparam logic [2:0]  OP_JUMP   = 3'd2;
  localparam logic [2:0]  OP_JR     = 3'd3;
  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] PC_LO     = 32'h0000_3000;
  localparam logic [31:0] PC_HI     = 32'h0000_6FFC;

  logic [31:0] r_pc;
  logic        r_adel;

  logic [31:0] w_seq;
  logic [31:0] w_dpc4;
  logic [31:0] w_btarget;
  logic [31:0] w_jtarget;
  logic [31:0] w_npc;
  logic        w_adel_nxt;
  logic        w_nullify_nxt;

  assign w_seq     = r_pc + 32'd4;
  assign w_dpc4    = D_PC + 32'd4;
  assign w_btarget = w_dpc4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
  assign w_jtarget = {w_dpc4[31:28], D_index, 2'b00};

  // Redirects come from D, so the delay slot has already been fetched via seq.
  always_comb begin
    w_npc         = w_seq;
    w_nullify_nxt = 1'b0;
    case (npc_op)
      OP_BRANCH: w_npc = cmp_out ? w_btarget : w_seq;
      OP_JUMP:   w_npc = w_jtarget;
      OP_JR:     w_npc = D_rs;
`ifdef PC_SEQUENCER_BLIKELY_EN
      3'd4: begin
        if (cmp_out) begin
          w_npc = w_btarget;
        end else begin
          w_nullify_nxt = 1'b1;
        end
      end
`endif
      default:   w_npc = w_seq;
    endcase
  end

  // Bad targets still load; the exception unit reacts to F_adel.
  assign w_adel_nxt = (w_npc[1:0] != 2'b00) || (w_npc < PC_LO) || (w_npc > PC_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= PC_RESET;
      r_adel <= 1'b0;
    end else if (!stall) begin
      r_pc   <= w_npc;
      r_adel <= w_adel_nxt;
    end
  end

`ifdef PC_SEQUENCER_BLIKELY_EN
  logic r_nullify;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nullify <= 1'b0;
    end else if (!stall) begin
      r_nullify <= w_nullify_nxt;
    end
  end

  assign F_nullify = r_nullify;
`else
  logic w_unused;
  assign w_unused  = w_nullify_nxt;
  assign F_nullify = 1'b0;
`endif

  assign F_PC    = r_pc;
  assign F_adel  = r_adel;
  assign link_pc = D_PC + 32'd8;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port stall, input, 1, hold fetch PC this cycle.
REQ-004 SHALL have port npc_op, input, 3, next-PC select: 0 SEQ, 1 BRANCH, 2 JUMP (j/jal), 3 JR, 4 BLIKELY (macro only), others treated as SEQ.
REQ-005 SHALL have port cmp_out, input, 1, branch condition from the D-stage comparator.
REQ-006 SHALL have port D_PC, input, 32, PC of the instruction in D.
REQ-007 SHALL have port D_imm16, input, 16, branch offset field.
REQ-008 SHALL have port D_index, input, 26, jump index field.
REQ-009 SHALL have port D_rs, input, 32, forwarded rs value for JR.
REQ-010 SHALL have port F_PC, output, 32, registered fetch PC.
REQ-011 SHALL have port link_pc, output, 32, combinational D_PC+8.
REQ-012 SHALL have port F_adel, output, 1, registered fetch-address-error flag.
REQ-013 SHALL have port F_nullify, output, 1, registered delay-slot kill flag (macro only; tied 0 otherwise).

Function
REQ-014 SHALL compute seq = F_PC+4, modulo 2^32.
REQ-015 SHALL compute btarget = D_PC + 4 + (sign-extended D_imm16 << 2), modulo 2^32.
REQ-016 SHALL compute jtarget = {(D_PC+4)[31:28], D_index, 2'b00}.
REQ-017 SHALL load on each edge with stall=0: SEQ->seq; BRANCH->btarget if cmp_out=1 else seq; JUMP->jtarget; JR->D_rs.
REQ-018 SHALL hold F_PC, F_adel and F_nullify unchanged on an edge with stall=1, regardless of npc_op or cmp_out.
REQ-019 SHALL set F_adel on the loading edge when the new PC has bits[1:0]!=0 or lies outside 0x00003000..0x00006FFC inclusive, and clear it otherwise.
REQ-020 SHALL still load a misaligned or out-of-range JR target into F_PC; F_adel is the only indication.
REQ-021 SHALL give a latency of one edge from a D-stage decision to the new F_PC, with the delay slot fetched from the old seq path.
REQ-022 SHALL drive link_pc purely combinationally, independent of stall and reset.

Reset
REQ-023 SHALL set F_PC=0x00003000, F_adel=0 and F_nullify=0 on any edge with reset=1.
REQ-024 SHALL give reset priority over stall and npc_op, including mid-redirect.
REQ-025 SHALL resume with seq from 0x00003000 on the first edge after reset deasserts.

Configuration
REQ-026 SHALL recognise the macro PC_SEQUENCER_BLIKELY_EN.
REQ-027 SHALL, with PC_SEQUENCER_BLIKELY_EN defined, handle npc_op=4 as follows: cmp_out=1 behaves as BRANCH taken with F_nullify<=0; cmp_out=0 loads seq and sets F_nullify<=1.
REQ-028 SHALL, with PC_SEQUENCER_BLIKELY_EN defined, clear F_nullify on every other non-stalled load.
REQ-029 SHALL, without PC_SEQUENCER_BLIKELY_EN, treat npc_op=4 as SEQ and tie F_nullify to constant 0.

Verification
REQ-030 SHALL cover reset then 3 free edges -> F_PC 0x3000, 0x3004, 0x3008, 0x300C; F_adel=0.
REQ-031 SHALL cover BRANCH with D_PC=0x3010, imm=0xFFFC, cmp_out=1 -> F_PC=0x3004; with cmp_out=0 -> F_PC=old+4.
REQ-032 SHALL cover JUMP with D_PC=0x3020, index=0x0000D00 -> F_PC=0x00003400; link_pc=0x3028.
REQ-033 SHALL cover JR with D_rs=0x3002 -> F_PC=0x3002, F_adel=1; then D_rs=0x7000 -> F_adel=1; then D_rs=0x3100 -> F_adel=0.
REQ-034 SHALL cover stall=1 with BRANCH taken for 2 edges -> F_PC unchanged; stall=0 -> target loaded; reset together with stall=1 -> F_PC=0x3000.
REQ-035 SHALL cover, with the macro defined, npc_op=4 and cmp_out=0 -> F_nullify=1 for one load; the next SEQ load -> F_nullify=0; without the macro, the same stimulus -> F_nullify=0 and F_PC=seq.
